// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the I2C APB sequencer: register map,
// command/status bit encodings, FSM state enums and the APB operation payload.
package i2c_seq_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned SADDR_W = 7;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned MAX_LEN = 8;

  localparam logic [ADDR_W-1:0] ADDR_PRESCALE = 8'h00;
  localparam logic [ADDR_W-1:0] ADDR_COMMAND  = 8'h01;
  localparam logic [ADDR_W-1:0] ADDR_STATUS   = 8'h02;
  localparam logic [ADDR_W-1:0] ADDR_TRANSMIT = 8'h03;
  localparam logic [ADDR_W-1:0] ADDR_RECEIVE  = 8'h04;
  localparam logic [ADDR_W-1:0] ADDR_ADDRESS  = 8'h05;

  localparam logic [DATA_W-1:0] CMD_EN   = 8'h80;
  localparam logic [DATA_W-1:0] CMD_TXW  = 8'h40;
  localparam logic [DATA_W-1:0] CMD_RXR  = 8'h20;
  localparam logic [DATA_W-1:0] CMD_RSTN = 8'h10;

  localparam int unsigned STS_TX_EMPTY = 6;
  localparam int unsigned STS_RX_EMPTY = 4;

  typedef enum logic [3:0] {
    S_IDLE, S_CFG_RST0, S_CFG_RST1, S_CFG_PRE, S_CFG_ADR,
    S_LOAD_ACC, S_LOAD_TX, S_LOAD_PUSH, S_LOAD_REL,
    S_START, S_POLL, S_DRAIN_POP, S_DRAIN_RD, S_DRAIN_REL,
    S_STOP, S_ABORT
  } seq_state_e;

  typedef enum logic [1:0] {APB_IDLE, APB_SETUP, APB_ACCESS} apb_state_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } apb_op_t;

endpackage

// File: rtl/i2c_apb_sequencer_apb.sv
// Single-transfer APB master engine. A start seen on the completing ACCESS
// cycle chains straight into the next SETUP so PSEL stays high.
module apb_master_port
  import i2c_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  apb_op_t           i_op,
  input  logic [DATA_W-1:0] i_prdata,
  input  logic              i_pready,
  output logic              o_done_c,
  output logic [DATA_W-1:0] o_rdata_c,
  output logic              o_psel,
  output logic              o_penable,
  output logic              o_pwrite,
  output logic [ADDR_W-1:0] o_paddr,
  output logic [DATA_W-1:0] o_pwdata
);

  apb_state_e        r_state;
  apb_state_e        w_next;
  logic              w_load;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;

  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    o_done_c = 1'b0;
    case (r_state)
      APB_IDLE: begin
        if (i_start) begin
          w_next = APB_SETUP;
          w_load = 1'b1;
        end
      end
      APB_SETUP: w_next = APB_ACCESS;
      APB_ACCESS: begin
        if (i_pready) begin
          o_done_c = 1'b1;
          if (i_start) begin
            w_next = APB_SETUP;
            w_load = 1'b1;
          end else begin
            w_next = APB_IDLE;
          end
        end
      end
      default: w_next = APB_IDLE;
    endcase
  end

  // Address/control/data captured once per transfer, stable through ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= APB_IDLE;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
    end else begin
      r_state   <= w_next;
      r_psel    <= (w_next != APB_IDLE);
      r_penable <= (w_next == APB_ACCESS);
      if (w_load) begin
        r_pwrite <= i_op.write;
        r_paddr  <= i_op.addr;
        r_pwdata <= i_op.wdata;
      end
    end
  end

  assign o_rdata_c = i_prdata;
  assign o_psel    = r_psel;
  assign o_penable = r_penable;
  assign o_pwrite  = r_pwrite;
  assign o_paddr   = r_paddr;
  assign o_pwdata  = r_pwdata;

endmodule

// File: rtl/i2c_apb_sequencer.sv
// Runs complete I2C transactions on the I2C master subsystem through its
// APB register interface, one request descriptor at a time.
module i2c_apb_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [SADDR_W-1:0] req_addr,
  input  logic               req_rw,
  input  logic [LEN_W-1:0]   req_len,
  input  logic [DATA_W-1:0]  req_prescale,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [DATA_W-1:0]  wr_data,
  output logic               rd_valid,
  output logic [DATA_W-1:0]  rd_data,
  output logic               rsp_valid,
  output logic               rsp_error,
  output logic               PSELx,
  output logic               PENABLE,
  output logic               PWRITE,
  output logic [ADDR_W-1:0]  PADDR,
  output logic [DATA_W-1:0]  PWDATA,
  input  logic [DATA_W-1:0]  PRDATA,
  input  logic               PREADY
);

  seq_state_e           r_state;
  seq_state_e           w_next;
  logic [SADDR_W-1:0]   r_addr;
  logic                 r_rw;
  logic [LEN_W-1:0]     r_len;
  logic [DATA_W-1:0]    r_pre;
  logic [LEN_W-1:0]     r_cnt;
  logic [LEN_W-1:0]     w_cnt;
  logic [TIMEOUT_W-1:0] r_tmo;
  logic [TIMEOUT_W-1:0] w_tmo;
  logic                 r_req_ready;
  logic                 r_wr_ready;
  logic                 r_rd_valid;
  logic [DATA_W-1:0]    r_rd_data;
  logic                 r_rsp_valid;
  logic                 r_rsp_error;
  logic                 w_issue;
  apb_op_t              w_op;
  logic                 w_done;
  logic [DATA_W-1:0]    w_rdata;
  logic                 w_req_acc;
  logic                 w_wr_acc;
  logic                 w_len_bad;
  logic                 w_poll_ok;
  logic                 w_rsp_valid;
  logic                 w_rsp_error;
  logic                 w_rd_valid;

  apb_master_port u_apb (
    .clk       (PCLK),
    .rst_n     (PRESETn),
    .i_start   (w_issue),
    .i_op      (w_op),
    .i_prdata  (PRDATA),
    .i_pready  (PREADY),
    .o_done_c  (w_done),
    .o_rdata_c (w_rdata),
    .o_psel    (PSELx),
    .o_penable (PENABLE),
    .o_pwrite  (PWRITE),
    .o_paddr   (PADDR),
    .o_pwdata  (PWDATA)
  );

  // Next state, and the next APB operation issued on the same cycle the previous one completes.
  always_comb begin
    w_next      = r_state;
    w_issue     = 1'b0;
    w_cnt       = r_cnt;
    w_tmo       = r_tmo;
    w_rsp_valid = 1'b0;
    w_rsp_error = 1'b0;
    w_rd_valid  = 1'b0;
    w_op        = '0;
    w_req_acc   = req_valid && r_req_ready;
    w_wr_acc    = wr_valid && r_wr_ready;
    w_len_bad   = (req_len == LEN_W'(0)) || (req_len > LEN_W'(MAX_LEN));
    w_poll_ok   = r_rw ? !w_rdata[STS_RX_EMPTY] : w_rdata[STS_TX_EMPTY];

    case (r_state)
      S_IDLE: begin
        if (w_req_acc) begin
          if (w_len_bad) begin
            w_rsp_valid = 1'b1;
            w_rsp_error = 1'b1;
          end else begin
            w_next  = S_CFG_RST0;
            w_issue = 1'b1;
            w_cnt   = '0;
          end
        end
      end
      S_CFG_RST0: if (w_done) begin w_next = S_CFG_RST1; w_issue = 1'b1; end
      S_CFG_RST1: if (w_done) begin w_next = S_CFG_PRE;  w_issue = 1'b1; end
      S_CFG_PRE:  if (w_done) begin w_next = S_CFG_ADR;  w_issue = 1'b1; end
      S_CFG_ADR: begin
        if (w_done) begin
          w_next  = r_rw ? S_START : S_LOAD_ACC;
          w_issue = r_rw;
        end
      end
      S_LOAD_ACC:  if (w_wr_acc) begin w_next = S_LOAD_TX; w_issue = 1'b1; end
      S_LOAD_TX:   if (w_done) begin w_next = S_LOAD_PUSH; w_issue = 1'b1; end
      S_LOAD_PUSH: if (w_done) begin w_next = S_LOAD_REL;  w_issue = 1'b1; end
      S_LOAD_REL: begin
        if (w_done) begin
          w_cnt = r_cnt + LEN_W'(1);
          if (w_cnt == r_len) begin
            w_next  = S_START;
            w_issue = 1'b1;
            w_cnt   = '0;
          end else begin
            w_next = S_LOAD_ACC;
          end
        end
      end
      S_START: begin
        if (w_done) begin
          w_next  = S_POLL;
          w_issue = 1'b1;
          w_tmo   = '1;
        end
      end
      S_POLL: begin
        if (w_done) begin
          w_issue = 1'b1;
          if (w_poll_ok) begin
            w_next = r_rw ? S_DRAIN_POP : S_STOP;
          end else begin
            w_tmo = r_tmo - TIMEOUT_W'(1);
            if (w_tmo == '0) w_next = S_ABORT;
          end
        end
      end
      S_DRAIN_POP: if (w_done) begin w_next = S_DRAIN_RD; w_issue = 1'b1; end
      S_DRAIN_RD: begin
        if (w_done) begin
          w_next     = S_DRAIN_REL;
          w_issue    = 1'b1;
          w_rd_valid = 1'b1;
          w_cnt      = r_cnt + LEN_W'(1);
          w_tmo      = '1;
        end
      end
      S_DRAIN_REL: begin
        if (w_done) begin
          w_next  = (r_cnt == r_len) ? S_STOP : S_POLL;
          w_issue = 1'b1;
          w_tmo   = '1;
        end
      end
      S_STOP: begin
        if (w_done) begin
          w_next      = S_IDLE;
          w_rsp_valid = 1'b1;
        end
      end
      S_ABORT: begin
        if (w_done) begin
          w_next      = S_IDLE;
          w_rsp_valid = 1'b1;
          w_rsp_error = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase

    case (w_next)
      S_CFG_RST0:  w_op = '{1'b1, ADDR_COMMAND, 8'h00};
      S_CFG_RST1:  w_op = '{1'b1, ADDR_COMMAND, CMD_RSTN};
      S_CFG_PRE:   w_op = '{1'b1, ADDR_PRESCALE, r_pre};
      S_CFG_ADR:   w_op = '{1'b1, ADDR_ADDRESS, {r_addr, r_rw}};
      S_LOAD_TX:   w_op = '{1'b1, ADDR_TRANSMIT, wr_data};
      S_LOAD_PUSH: w_op = '{1'b1, ADDR_COMMAND, CMD_TXW | CMD_RSTN};
      S_LOAD_REL:  w_op = '{1'b1, ADDR_COMMAND, CMD_RSTN};
      S_START:     w_op = '{1'b1, ADDR_COMMAND, CMD_EN | CMD_RSTN};
      S_POLL:      w_op = '{1'b0, ADDR_STATUS, 8'h00};
      S_DRAIN_POP: w_op = '{1'b1, ADDR_COMMAND, CMD_EN | CMD_RXR | CMD_RSTN};
      S_DRAIN_RD:  w_op = '{1'b0, ADDR_RECEIVE, 8'h00};
      S_DRAIN_REL: w_op = '{1'b1, ADDR_COMMAND, CMD_EN | CMD_RSTN};
      S_STOP:      w_op = '{1'b1, ADDR_COMMAND, CMD_RSTN};
      S_ABORT:     w_op = '{1'b1, ADDR_COMMAND, 8'h00};
      default:     w_op = '0;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_rw        <= 1'b0;
      r_len       <= '0;
      r_pre       <= '0;
      r_cnt       <= '0;
      r_tmo       <= '1;
      r_req_ready <= 1'b0;
      r_wr_ready  <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_error <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_cnt;
      r_tmo       <= w_tmo;
      r_req_ready <= (w_next == S_IDLE);
      r_wr_ready  <= (w_next == S_LOAD_ACC);
      r_rd_valid  <= w_rd_valid;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_error <= w_rsp_error;
      if (w_rd_valid) r_rd_data <= w_rdata;
      if (w_req_acc) begin
        r_addr <= req_addr;
        r_rw   <= req_rw;
        r_len  <= req_len;
        r_pre  <= req_prescale;
      end
    end
  end

  assign req_ready = r_req_ready;
  assign wr_ready  = r_wr_ready;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign rsp_valid = r_rsp_valid;
  assign rsp_error = r_rsp_error;

endmodule
